uart_value_reporter: RTL and testbench
======================================

# uart_value_reporter

Formats a 16-bit binary sample as a fixed 9-byte ASCII line, e.g. `V=01234\r\n`, and hands it to the UART transmit supervisor. It sits directly upstream of that supervisor, driving its begin/data/length inputs and consuming its busy/done outputs. Binary-to-decimal conversion uses a sequential double-dabble, one shift per clock. A one-deep pending register absorbs samples that arrive while a report is in flight.

## Interface
- LABEL, 8'h56 ('V'): first byte of every message
- SEPARATOR, 8'h3D ('='): second byte of every message
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_sample  in  16  unsigned value to report
- i_sampleValid  in  1  one-cycle strobe; i_sample is valid this cycle
- i_txBusy  in  1  supervisor busy
- i_txDone  in  1  supervisor one-cycle done pulse
- o_txBegin  out  1  one-cycle start strobe to supervisor
- o_txData  out  112  message; first byte sent is at [71:64]
- o_txDataLength  out  8  byte count; always 9 while a message is presented
- o_busy  out  1  high when state != IDLE or a pending sample is held
- o_reportDone  out  1  one-cycle pulse when a message completes
- o_dropCount  out  8  samples overwritten or discarded; saturates at 255

## Operation
- States: IDLE, CONVERT, LOAD, START, WAIT.
- IDLE:
  - If i_sampleValid, latch i_sample; go to CONVERT.
  - Else if a sample is pending, latch the pending value, clear the pending flag, go to CONVERT.
  - If both occur in the same cycle, i_sampleValid wins, the pending sample is discarded, and o_dropCount increments.
- CONVERT: 16 cycles of double-dabble on a 20-bit BCD register.
  - Each cycle, every nibble >= 5 gets +3, then {bcd, bin} shifts left by 1.
  - A 5-bit counter ends the state after exactly 16 shifts.
- LOAD: assemble o_txData.
  - [111:72] = 0.
  - [71:64] = LABEL; [63:56] = SEPARATOR.
  - [55:16] = ASCII digits d4..d0, each 8'h30 + nibble, most significant first.
  - [15:8] = 8'h0D; [7:0] = 8'h0A.
  - o_txDataLength = 9.
- START: wait while i_txBusy = 1. On the first cycle with i_txBusy = 0, assert o_txBegin for exactly that one cycle and go to WAIT.
- WAIT: on i_txDone = 1, pulse o_reportDone and go to IDLE. All other inputs are ignored except the sample capture described below.
- Sample capture outside IDLE: i_sampleValid stores into the pending register and sets the pending flag.
  - If the flag was already set, the old pending value is overwritten and o_dropCount increments.
- o_dropCount never wraps: holding at 255, it stays 255.
- o_txData and o_txDataLength are held stable from the cycle after LOAD until exit from WAIT. They may change only in LOAD.

## Timing
- Reset values:
  - o_txBegin = 0, o_reportDone = 0, o_busy = 0.
  - o_txData = 0, o_txDataLength = 0, o_dropCount = 0.
  - Pending flag cleared; state = IDLE.
- Reset has priority over all other inputs in every state. Reset mid-CONVERT or mid-WAIT abandons the message with no o_txBegin and no o_reportDone.
- Latency with the supervisor idle:
  - i_sampleValid at cycle N (in IDLE).
  - CONVERT spans N+1..N+16; LOAD is N+17.
  - START, and o_txBegin high, is N+18.
- Supervisor response: i_txBusy rises at N+19. i_txDone arrives after all 9 bytes, and o_reportDone is high in the same cycle that i_txDone is sampled.
- After WAIT, a pending sample begins conversion on the next IDLE cycle. Minimum gap between o_reportDone and the next o_txBegin is 19 cycles.
- The supervisor has no reset, so after i_reset it may still be sending. START therefore never asserts o_txBegin while i_txBusy = 1. A stale i_txDone that arrives before WAIT is ignored.

## Test plan
- Sample 16'd12345, supervisor idle:
  - o_txBegin exactly 18 cycles after the strobe.
  - o_txData = 112'h563D31323334350D0A, length 9.
  - Serial line carries 56 3D 31 32 33 34 35 0D 0A; o_reportDone pulses once.
- Samples 0 and 65535 -> digit fields 30 30 30 30 30 and 36 35 35 33 35 respectively.
- Sample A, then B and C strobed during WAIT:
  - C is reported next, B is never sent, o_dropCount = 1.
  - 300 overwrites -> o_dropCount holds at 255.
- i_txBusy forced high across START for 40 cycles:
  - o_txBegin stays 0.
  - Exactly one o_txBegin pulse in the cycle i_txBusy drops; o_txData unchanged throughout.
- i_reset asserted mid-CONVERT and mid-WAIT:
  - All outputs at reset values next cycle.
  - No o_reportDone; a fresh sample afterwards reports correctly.
- i_sampleValid and pending coincident in IDLE -> new sample reported, o_dropCount increments by 1.

Source files
------------

// File: rtl/uart_value_reporter.sv
// Turns a 16-bit sample into the 9-byte ASCII line "V=ddddd\r\n" and hands it
// to the UART transmit supervisor. A one-deep pending slot holds a sample that arrives mid-report.
module uart_value_reporter (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [15:0]  i_sample,
    input  logic         i_sampleValid,
    input  logic         i_txBusy,
    input  logic         i_txDone,
    output logic         o_txBegin,
    output logic [111:0] o_txData,
    output logic [7:0]   o_txDataLength,
    output logic         o_busy,
    output logic         o_reportDone,
    output logic [7:0]   o_dropCount
);
    localparam logic [7:0] LABEL     = 8'h56;
    localparam logic [7:0] SEPARATOR = 8'h3D;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;

    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, START, WAIT} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] bin;
    logic [19:0] bcd;
    logic [19:0] bcd_adj;
    logic [4:0]  shift_count;
    logic        pending;
    logic [15:0] pending_value;
    logic        drop_event;

    always_ff @(posedge i_clock) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // Strobes are masked during reset so an abandoned message never leaks a begin or done.
    always_comb begin
        state_next   = state;
        o_txBegin    = 1'b0;
        o_reportDone = 1'b0;
        case (state)
            IDLE:    if (i_sampleValid || pending) state_next = CONVERT;
            CONVERT: if (shift_count == 5'd15) state_next = LOAD;
            LOAD:    state_next = START;
            START: begin
                if (!i_txBusy) begin
                    o_txBegin  = !i_reset;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (i_txDone) begin
                    o_reportDone = !i_reset;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // A sample is lost whenever a new strobe meets an occupied pending slot, in any state.
    always_comb drop_event = i_sampleValid && pending;

    always_comb o_busy = (state != IDLE) || pending;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            bin            <= '0;
            bcd            <= '0;
            shift_count    <= '0;
            pending        <= 1'b0;
            pending_value  <= '0;
            o_txData       <= '0;
            o_txDataLength <= '0;
            o_dropCount    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bcd         <= '0;
                    shift_count <= '0;
                    if (i_sampleValid || pending) begin
                        bin     <= i_sampleValid ? i_sample : pending_value;
                        pending <= 1'b0;
                    end
                end
                CONVERT: begin
                    {bcd, bin}  <= {bcd_adj, bin} << 1;
                    shift_count <= shift_count + 5'd1;
                end
                LOAD: begin
                    o_txData <= {40'h0, LABEL, SEPARATOR,
                                 4'h3, bcd[19:16], 4'h3, bcd[15:12], 4'h3, bcd[11:8],
                                 4'h3, bcd[7:4], 4'h3, bcd[3:0], CR, LF};
                    o_txDataLength <= 8'd9;
                end
                default: ;
            endcase

            if (state != IDLE && i_sampleValid) begin
                pending       <= 1'b1;
                pending_value <= i_sample;
            end

            if (drop_event && o_dropCount != 8'hFF) o_dropCount <= o_dropCount + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_value_reporter.sv
// Bench for uart_value_reporter: a cycle-level reference model checks every output every cycle,
// plus table vectors and directed sequences against a behavioural supervisor.
module tb_uart_value_reporter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         valid = 1'b0;
    logic [15:0]  sample = '0;
    logic         sup_busy = 1'b0, force_busy = 1'b0, sup_done = 1'b0, stale_done = 1'b0;
    logic         tx_busy, tx_done;
    logic         tx_begin, busy, report_done;
    logic [111:0] tx_data;
    logic [7:0]   tx_len, drop_count;

    assign tx_busy = sup_busy | force_busy;
    assign tx_done = sup_done | stale_done;

    uart_value_reporter dut (
        .i_clock(clk), .i_reset(rst), .i_sample(sample), .i_sampleValid(valid),
        .i_txBusy(tx_busy), .i_txDone(tx_done), .o_txBegin(tx_begin), .o_txData(tx_data),
        .o_txDataLength(tx_len), .o_busy(busy), .o_reportDone(report_done),
        .o_dropCount(drop_count)
    );

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line straight from decimal arithmetic.
    function automatic logic [111:0] msg(input int v);
        logic [111:0] m;
        int p;
        m = '0;
        m[71:64] = 8'h56;
        m[63:56] = 8'h3D;
        m[15:8]  = 8'h0D;
        m[7:0]   = 8'h0A;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            m[16 + 8*k +: 8] = 8'(48 + (v / p) % 10);
            p = p * 10;
        end
        return m;
    endfunction

    // Observation state, filled in at the falling edge.
    int           cyc = 0, begin_cnt = 0, done_cnt = 0, begin_cyc = 0, strobe_cyc = 0;
    logic [111:0] begin_data = '0;
    bit           begin_seen = 1'b0;
    logic [7:0]   line_q[$];

    // Reference model: report in flight with an age in cycles since acceptance.
    bit           m_inflight = 0, m_began = 0, m_pend = 0;
    int           m_age = 0, m_drops = 0;
    logic [15:0]  m_pend_val = '0, m_cur = '0;
    logic [111:0] m_data = '0;
    logic [7:0]   m_len = '0;
    bit           exp_begin, exp_done;

    always @(negedge clk) begin
        cyc++;
        exp_begin = m_inflight && !m_began && m_age >= 18 && !tx_busy && !rst;
        exp_done  = m_inflight && m_began && tx_done && !rst;
        check("model_begin", tx_begin, exp_begin);
        check("model_done", report_done, exp_done);
        check("model_busy", busy, m_inflight || m_pend);
        check("model_data", tx_data, m_data);
        check("model_len", tx_len, m_len);
        check("model_drops", drop_count, m_drops);

        if (tx_begin) begin
            begin_seen = 1'b1;
            begin_cnt++;
            begin_cyc  = cyc;
            begin_data = tx_data;
            for (int b = 8; b >= 0; b--) line_q.push_back(tx_data[b*8 +: 8]);
        end
        if (report_done) done_cnt++;

        if (rst) begin
            m_inflight = 0; m_began = 0; m_pend = 0; m_drops = 0;
            m_data = '0; m_len = '0;
        end else if (m_inflight) begin
            if (valid) begin
                if (m_pend && m_drops < 255) m_drops++;
                m_pend = 1; m_pend_val = sample;
            end
            if (m_age == 17) begin m_data = msg(m_cur); m_len = 8'd9; end
            if (exp_begin) m_began = 1;
            if (exp_done) m_inflight = 0;
            m_age++;
        end else if (valid || m_pend) begin
            if (valid) begin
                if (m_pend && m_drops < 255) m_drops++;
                m_cur = sample;
                strobe_cyc = cyc;
            end else begin
                m_cur = m_pend_val;
            end
            m_pend = 0; m_inflight = 1; m_began = 0; m_age = 1;
        end
    end

    // Supervisor: busy from the cycle after begin, done pulse after the 9 bytes, ignores reset.
    int sup_cnt = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            sup_done = 1'b0;
            if (sup_cnt > 0) begin
                sup_cnt--;
                if (sup_cnt == 0) begin sup_busy = 1'b0; sup_done = 1'b1; end
            end else if (begin_seen) begin
                begin_seen = 1'b0; sup_busy = 1'b1; sup_cnt = 27;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic strobe(input logic [15:0] v);
        sample = v; valid = 1'b1; tick(1); valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(1); rst = 1'b0;
    endtask

    task automatic wait_begins(input int target, input int max);
        int n = 0;
        while (begin_cnt < target && n < max) begin tick(1); n++; end
        check("wait_begin_timeout", begin_cnt >= target, 1);
    endtask

    task automatic wait_reports(input int target, input int max);
        int n = 0;
        while (done_cnt < target && n < max) begin tick(1); n++; end
        check("wait_done_timeout", done_cnt >= target, 1);
    endtask

    typedef struct { logic [15:0] smp; logic [111:0] data; } vec_t;
    vec_t vecs[5];
    logic [7:0] exp_line[9] = '{8'h56, 8'h3D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc0, dc0;
        logic [15:0] a, b, c;
        vecs[0] = '{16'd12345, 112'h563D31323334350D0A};
        vecs[1] = '{16'd0,     112'h563D30303030300D0A};
        vecs[2] = '{16'd65535, 112'h563D36353533350D0A};
        vecs[3] = '{16'd1000,  112'h563D30313030300D0A};
        vecs[4] = '{16'd9,     112'h563D30303030390D0A};

        tick(3); rst = 1'b0;
        @(negedge clk);
        check("reset_data", tx_data, 0);
        check("reset_len", tx_len, 0);
        check("reset_busy", busy, 0);
        check("reset_begin", tx_begin, 0);
        tick(1);

        foreach (vecs[i]) begin
            bc0 = begin_cnt; dc0 = done_cnt;
            line_q.delete();
            strobe(vecs[i].smp);
            wait_reports(dc0 + 1, 200);
            tick(5);
            check("vec_latency", begin_cyc - strobe_cyc, 18);
            check("vec_data", begin_data, vecs[i].data);
            check("vec_len", tx_len, 9);
            check("vec_begins", begin_cnt - bc0, 1);
            check("vec_dones", done_cnt - dc0, 1);
            if (i == 0) begin
                check("line_size", line_q.size(), 9);
                for (int k = 0; k < 9 && k < line_q.size(); k++) check("line_byte", line_q[k], exp_line[k]);
            end
        end

        // A, then B and C during WAIT: C wins, B is dropped.
        do_reset();
        a = 16'd111; b = 16'd22222; c = 16'd3033;
        bc0 = begin_cnt; dc0 = done_cnt;
        strobe(a);
        wait_begins(bc0 + 1, 100);
        tick(2);
        strobe(b); strobe(c);
        @(negedge clk); check("abc_drop", drop_count, 1);
        wait_reports(dc0 + 2, 300);
        tick(3);
        check("abc_data", begin_data, msg(c));
        check("abc_begins", begin_cnt - bc0, 2);

        // 300 overwrites while held in START.
        force_busy = 1'b1;
        strobe(16'd4242);
        tick(2);
        valid = 1'b1;
        for (int k = 0; k < 300; k++) begin sample = 16'($urandom); tick(1); end
        valid = 1'b0;
        @(negedge clk); check("drop_saturate", drop_count, 255);
        tick(1);
        force_busy = 1'b0;
        dc0 = done_cnt;
        wait_reports(dc0 + 2, 300);
        check("drop_hold", drop_count, 255);

        // Busy held across START for 40 cycles.
        do_reset();
        force_busy = 1'b1;
        bc0 = begin_cnt;
        strobe(16'd777);
        tick(20);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check("hold_no_begin", tx_begin, 0);
            check("hold_data", tx_data, msg(777));
            tick(1);
        end
        force_busy = 1'b0;
        @(negedge clk);
        check("hold_begin_on_drop", tx_begin, 1);
        tick(4);
        check("hold_one_begin", begin_cnt - bc0, 1);
        wait_reports(done_cnt + 1, 100);

        // Reset mid-CONVERT.
        strobe(16'd5555);
        tick(5);
        do_reset();
        @(negedge clk);
        check("rstconv_data", tx_data, 0);
        check("rstconv_busy", busy, 0);
        check("rstconv_drops", drop_count, 0);
        bc0 = begin_cnt; dc0 = done_cnt;
        tick(30);
        check("rstconv_no_begin", begin_cnt - bc0, 0);

        // Reset mid-WAIT; the supervisor's late done must be ignored.
        strobe(16'd808);
        wait_begins(bc0 + 1, 100);
        tick(3);
        dc0 = done_cnt;
        do_reset();
        @(negedge clk);
        check("rstwait_data", tx_data, 0);
        check("rstwait_len", tx_len, 0);
        check("rstwait_done_out", report_done, 0);
        tick(40);
        check("rstwait_no_done", done_cnt - dc0, 0);
        dc0 = done_cnt;
        strobe(16'd31415);
        wait_reports(dc0 + 1, 200);
        check("rstwait_fresh", begin_data, msg(31415));

        // Pending and a new strobe meet in the first IDLE cycle.
        do_reset();
        bc0 = begin_cnt; dc0 = done_cnt;
        strobe(16'd100);
        wait_begins(bc0 + 1, 100);
        tick(2);
        strobe(16'd200);
        wait_reports(dc0 + 1, 100);
        strobe(16'd300);
        @(negedge clk); check("coincide_drop", drop_count, 1);
        wait_reports(dc0 + 2, 200);
        check("coincide_data", begin_data, msg(300));
        check("coincide_begins", begin_cnt - bc0, 2);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            valid      = ($urandom_range(99) < 4);
            sample     = 16'($urandom);
            stale_done = ($urandom_range(199) == 0);
            if ($urandom_range(49) == 0) force_busy = ~force_busy;
            rst        = ($urandom_range(499) == 0);
            tick(1);
        end
        valid = 1'b0; stale_done = 1'b0; force_busy = 1'b0; rst = 1'b0;
        tick(300);
        @(negedge clk); check("drain_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
